// File: rtl/spi_transaction_fsm_pkg.sv
// Shared types and constants for the SPI transaction controller.
// The state encoding and edge-select type are used by the FSM and the
// bit counter; the R/W constants give the command LSB its meaning.
package spi_pkg;

  // Transaction sequencing states.
  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    GET_ADDR     = 4'd1,
    ADDR_WAIT    = 4'd2,
    DECODE       = 4'd3,
    READ_LOAD    = 4'd4,
    READ_SHIFT   = 4'd5,
    WRITE_GET    = 4'd6,
    WRITE_WAIT   = 4'd7,
    WRITE_COMMIT = 4'd8,
    DONE         = 4'd9
  } spiState_t;

  // Which SCLK edge pulse the bit counter listens to.
  typedef enum logic {
    EDGE_POS = 1'b0,
    EDGE_NEG = 1'b1
  } edgeSel_t;

  // Value of the command byte LSB.
  localparam logic SPI_RW_READ  = 1'b1;
  localparam logic SPI_RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_transaction_fsm_if.sv
// Bus between the transaction controller and the SPI datapath.
// master: the controller side (consumes conditioned inputs and the shift
//         register contents, drives the sequencing strobes).
// slave:  the datapath side (input conditioners, shift register, data
//         memory, address latch, MISO buffer).
interface spi_transaction_fsm_if #(
  parameter int DATA_BITS = 8
);

  logic                 cs_n;
  logic                 sclk_pos_edge;
  logic                 sclk_neg_edge;
  logic [DATA_BITS-1:0] sr_pout;
  logic                 sr_load;
  logic                 addr_we;
  logic                 dm_we;
  logic                 miso_en;
  logic                 busy;

  modport master (
    input  cs_n,
    input  sclk_pos_edge,
    input  sclk_neg_edge,
    input  sr_pout,
    output sr_load,
    output addr_we,
    output dm_we,
    output miso_en,
    output busy
  );

  modport slave (
    output cs_n,
    output sclk_pos_edge,
    output sclk_neg_edge,
    output sr_pout,
    input  sr_load,
    input  addr_we,
    input  dm_we,
    input  miso_en,
    input  busy
  );

endinterface

// File: rtl/spi_transaction_fsm_bit_counter.sv
// Bit counter for the SPI transaction controller.
// Counts the selected SCLK edge pulse while enabled and saturates at
// DATA_BITS. 'done' looks ahead: it is already high in the cycle that
// carries the DATA_BITS-th pulse, so the FSM can leave the counting state
// on that very pulse instead of one clk later.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     clear,
  input  logic     countEn,
  input  edgeSel_t edgeSel,
  input  logic     sclkPosEdge,
  input  logic     sclkNegEdge,
  output logic     done
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] countReg;
  logic             edgePulse;
  logic             step;

  assign edgePulse = (edgeSel == EDGE_NEG) ? sclkNegEdge : sclkPosEdge;

  // A pulse only advances the count below DATA_BITS, so it never wraps.
  assign step = countEn && edgePulse && (countReg != CNT_FULL);

  // Bit count register: clear has priority over counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      countReg <= '0;
    end else if (clear) begin
      countReg <= '0;
    end else if (step) begin
      countReg <= countReg + CNT_ONE;
    end
  end

  assign done = (countReg == CNT_FULL) || (step && (countReg == CNT_LAST));

endmodule

// File: rtl/spi_transaction_fsm.sv
// SPI transaction controller.
// Follows chip select and the conditioned SCLK edge pulses, counts the
// command and data bits, decodes R/W from the command LSB and sequences
// the address latch, shift register load, data memory write and MISO
// enable. All outputs are decoded from the registered state only, so no
// input reaches an output combinationally and reset clears them at once.
module spi_transaction_fsm
  import spi_pkg::*;
#(
  parameter int ADDR_BITS  = 7,
  parameter int DATA_BITS  = 8,
  parameter int SR_LATENCY = 2   // must be at least 1
) (
  input logic                  clk,
  input logic                  reset_n,
  spi_transaction_fsm_if.master bus
);

  // Command byte layout: {address[ADDR_BITS-1:0], rw}; ADDR_BITS+1 == DATA_BITS.
  localparam int RW_BIT = DATA_BITS - ADDR_BITS - 1;

  // Wait counter covers 0 .. SR_LATENCY-1.
  localparam int WAIT_W = (SR_LATENCY > 1) ? $clog2(SR_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SR_LATENCY - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  spiState_t         stateReg;
  spiState_t         stateNext;
  logic              rwReg;
  logic [WAIT_W-1:0] waitReg;

  logic              cntClear;
  logic              cntEn;
  edgeSel_t          cntEdgeSel;
  logic              cntDone;

  logic              rwBit;
  logic              inWaitState;
  logic              unusedAddrBits;

  assign rwBit = bus.sr_pout[RW_BIT];

  // The address bits go straight from the shift register to the address
  // latch; this block only needs the R/W bit.
  assign unusedAddrBits = ^bus.sr_pout[DATA_BITS-1:RW_BIT+1];

  assign inWaitState = (stateReg == ADDR_WAIT) || (stateReg == WRITE_WAIT);

  spi_bit_counter #(
    .DATA_BITS (DATA_BITS)
  ) bitCounter (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (cntClear),
    .countEn     (cntEn),
    .edgeSel     (cntEdgeSel),
    .sclkPosEdge (bus.sclk_pos_edge),
    .sclkNegEdge (bus.sclk_neg_edge),
    .done        (cntDone)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // R/W flag, captured from the command LSB in DECODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rwReg <= SPI_RW_WRITE;
    end else if (stateReg == DECODE) begin
      rwReg <= rwBit;
    end
  end

  // Shift-register latency timer: runs while a wait state is held, restarts otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waitReg <= '0;
    end else if (inWaitState && (stateNext == stateReg)) begin
      waitReg <= waitReg + WAIT_ONE;
    end else begin
      waitReg <= '0;
    end
  end

  // Next-state and bit-counter control; chip select high overrides everything.
  always_comb begin
    stateNext  = stateReg;
    cntClear   = 1'b0;
    cntEn      = 1'b0;
    cntEdgeSel = EDGE_POS;

    case (stateReg)
      IDLE: begin
        cntClear = 1'b1;
        if (!bus.cs_n) begin
          stateNext = GET_ADDR;
        end
      end

      GET_ADDR: begin
        cntEn = 1'b1;
        if (cntDone) begin
          stateNext = ADDR_WAIT;
        end
      end

      ADDR_WAIT: begin
        if (waitReg == WAIT_LAST) begin
          stateNext = DECODE;
        end
      end

      DECODE: begin
        cntClear  = 1'b1;
        stateNext = (rwBit == SPI_RW_READ) ? READ_LOAD : WRITE_GET;
      end

      READ_LOAD: begin
        // rwReg was captured in DECODE and always reads back as a read here;
        // checking it keeps a corrupted flag from driving MISO.
        stateNext = (rwReg == SPI_RW_READ) ? READ_SHIFT : DONE;
      end

      READ_SHIFT: begin
        cntEn      = 1'b1;
        cntEdgeSel = EDGE_NEG;
        if (cntDone) begin
          stateNext = DONE;
        end
      end

      WRITE_GET: begin
        cntEn = 1'b1;
        if (cntDone) begin
          stateNext = WRITE_WAIT;
        end
      end

      WRITE_WAIT: begin
        if (waitReg == WAIT_LAST) begin
          stateNext = WRITE_COMMIT;
        end
      end

      WRITE_COMMIT: begin
        stateNext = DONE;
      end

      DONE: begin
        stateNext = DONE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    if (bus.cs_n) begin
      stateNext = IDLE;
    end
  end

  // Strobes and enables decoded from the registered state.
  assign bus.addr_we = (stateReg == DECODE);
  assign bus.sr_load = (stateReg == READ_LOAD);
  assign bus.dm_we   = (stateReg == WRITE_COMMIT);
  assign bus.miso_en = (stateReg == READ_SHIFT);
  assign bus.busy    = (stateReg != IDLE);

endmodule
